// File: rtl/fxp_pkg.sv
// Shared types and helpers for the fixed-point 2x2 matrix inverter.
package fxp_pkg;

   // Widest magnitude and result handled by sat_signed.
   localparam int unsigned SAT_MAG_W = 128;
   localparam int unsigned SAT_RES_W = 64;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LATCH = 3'd1,
      S_DIV   = 3'd2,
      S_MUL0  = 3'd3,
      S_MUL1  = 3'd4,
      S_MUL2  = 3'd5,
      S_MUL3  = 3'd6,
      S_DONE  = 3'd7
   } inv_state_e;

   // Fractional bits left over after the integer digits (sign included).
   function automatic int unsigned frac_bits(input int unsigned width, input int unsigned int_digits);
      return width - int_digits;
   endfunction

   // Apply a sign to a magnitude, clamping to the signed range of 'width' bits.
   function automatic logic [SAT_RES_W-1:0] sat_signed(input logic [SAT_MAG_W-1:0] mag,
                                                       input logic neg,
                                                       input int unsigned width);
      logic [SAT_RES_W-1:0] lim_pos;
      logic [SAT_RES_W-1:0] lim_neg;
      lim_neg = SAT_RES_W'(1) << (width - 1);
      lim_pos = lim_neg - SAT_RES_W'(1);
      if (!neg)
         return (mag > SAT_MAG_W'(lim_pos)) ? lim_pos : SAT_RES_W'(mag);
      return (mag > SAT_MAG_W'(lim_neg)) ? (SAT_RES_W'(0) - lim_neg)
                                         : (SAT_RES_W'(0) - SAT_RES_W'(mag));
   endfunction

endpackage

// File: rtl/seq_divider_u.sv
// Unsigned restoring divider, one quotient bit per enabled cycle, N cycles per divide.
module seq_divider_u #(
   parameter int unsigned N = 33
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clk_en,
   input  logic         start,
   input  logic [N-1:0] dividend,
   input  logic [N-1:0] divisor,
   output logic [N-1:0] quotient,
   output logic         busy,
   output logic         done
);

   localparam int unsigned CW = $clog2(N + 1);

   logic [N-1:0]  rem_q;
   logic [CW-1:0] cnt_q;
   logic [N-1:0]  rem_in_c;
   logic [N-1:0]  quo_in_c;
   logic [N:0]    shift_c;
   logic          ge_c;
   logic [N-1:0]  rem_nxt_c;
   logic [N-1:0]  quo_nxt_c;

   // One restoring step; the first step is folded into the start cycle.
   always_comb begin
      rem_in_c  = start ? '0 : rem_q;
      quo_in_c  = start ? dividend : quotient;
      shift_c   = {rem_in_c, quo_in_c[N-1]};
      ge_c      = (shift_c >= {1'b0, divisor});
      rem_nxt_c = ge_c ? N'(shift_c - {1'b0, divisor}) : shift_c[N-1:0];
      quo_nxt_c = {quo_in_c[N-2:0], ge_c};
   end

   // Iteration registers and the one-cycle done pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         rem_q    <= '0;
         quotient <= '0;
         cnt_q    <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else if (clk_en) begin
         done <= 1'b0;
         if (start) begin
            rem_q    <= rem_nxt_c;
            quotient <= quo_nxt_c;
            cnt_q    <= CW'(N - 1);
            busy     <= 1'b1;
         end else if (busy) begin
            rem_q    <= rem_nxt_c;
            quotient <= quo_nxt_c;
            cnt_q    <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               busy <= 1'b0;
               done <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/fxp_matrix_inv_2x2_seq.sv
// Sequential signed fixed-point 2x2 matrix inverter: det, 1/|det| by division, then adj(A)/det.
module fxp_matrix_inv_2x2_seq
   import fxp_pkg::*;
#(
   parameter int unsigned WIDTH      = 16,
   parameter int unsigned INT_DIGITS = 10,
   parameter bit          SAT_EN     = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clk_en,
   input  logic                    start,
   input  logic signed [WIDTH-1:0] A   [0:1][0:1],
   output logic signed [WIDTH-1:0] Res [0:1][0:1],
   output logic                    busy,
   output logic                    done,
   output logic                    singular
);

   localparam int unsigned FRAC = frac_bits(WIDTH, INT_DIGITS);
   localparam int unsigned DW   = 2 * WIDTH + 1;
   localparam int unsigned PW   = 3 * WIDTH + 2;
   localparam logic [DW-1:0] RECIP_NUM = DW'(1) << (3 * FRAC);

   localparam logic [2:0] ST_IDLE  = S_IDLE;
   localparam logic [2:0] ST_LATCH = S_LATCH;
   localparam logic [2:0] ST_DIV   = S_DIV;
   localparam logic [2:0] ST_MUL0  = S_MUL0;
   localparam logic [2:0] ST_MUL1  = S_MUL1;
   localparam logic [2:0] ST_MUL2  = S_MUL2;
   localparam logic [2:0] ST_MUL3  = S_MUL3;
   localparam logic [2:0] ST_DONE  = S_DONE;

   logic [2:0]              state;
   logic [2:0]              state_nxt;
   logic signed [WIDTH-1:0] areg [0:1][0:1];
   logic                    det_neg_q;
   logic [DW-1:0]           recip_q;

   logic signed [DW-1:0]    det_c;
   logic [DW-1:0]           det_mag_c;
   logic                    det_zero_c;
   logic                    div_start_c;
   logic                    div_take_c;
   logic [DW-1:0]           div_quot;
   logic                    div_busy;
   logic                    div_done;

   logic                    is_mul_c;
   logic [1:0]              mul_idx_c;
   logic signed [WIDTH-1:0] adj_src_c;
   logic                    adj_flip_c;
   logic signed [WIDTH:0]   adj_ext_c;
   logic [WIDTH:0]          adj_mag_c;
   logic                    res_neg_c;
   logic [PW-1:0]           prod_c;
   logic [PW-1:0]           mag_c;
   logic [WIDTH-1:0]        res_c;

   // Determinant in full precision and its magnitude for the divider.
   always_comb begin
      det_c      = DW'(areg[0][0]) * DW'(areg[1][1]) - DW'(areg[0][1]) * DW'(areg[1][0]);
      det_mag_c  = det_c[DW-1] ? $unsigned(-det_c) : $unsigned(det_c);
      det_zero_c = (det_c == '0);
      div_take_c = div_done & ~div_busy;
   end

   seq_divider_u #(.N(DW)) u_div (
      .clk      (clk),
      .rst      (rst),
      .clk_en   (clk_en),
      .start    (div_start_c),
      .dividend (RECIP_NUM),
      .divisor  (det_mag_c),
      .quotient (div_quot),
      .busy     (div_busy),
      .done     (div_done)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst)         state <= ST_IDLE;
      else if (clk_en) state <= state_nxt;
   end

   // Next-state logic and divider launch.
   always_comb begin
      state_nxt   = state;
      div_start_c = 1'b0;
      case (state)
         ST_IDLE:  if (start) state_nxt = ST_LATCH;
         ST_LATCH: begin
            if (det_zero_c) begin
               state_nxt = ST_DONE;
            end else begin
               state_nxt   = ST_DIV;
               div_start_c = 1'b1;
            end
         end
         ST_DIV:   if (div_take_c) state_nxt = ST_MUL0;
         ST_MUL0:  state_nxt = ST_MUL1;
         ST_MUL1:  state_nxt = ST_MUL2;
         ST_MUL2:  state_nxt = ST_MUL3;
         ST_MUL3:  state_nxt = ST_DONE;
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // Shared multiplier: sign-magnitude adj element times reciprocal, truncated toward zero.
   always_comb begin
      is_mul_c   = 1'b0;
      mul_idx_c  = 2'd0;
      case (state)
         ST_MUL0: begin is_mul_c = 1'b1; mul_idx_c = 2'd0; end
         ST_MUL1: begin is_mul_c = 1'b1; mul_idx_c = 2'd1; end
         ST_MUL2: begin is_mul_c = 1'b1; mul_idx_c = 2'd2; end
         ST_MUL3: begin is_mul_c = 1'b1; mul_idx_c = 2'd3; end
         default: ;
      endcase
      case (mul_idx_c)
         2'd0:    begin adj_src_c = areg[1][1]; adj_flip_c = 1'b0; end
         2'd1:    begin adj_src_c = areg[0][1]; adj_flip_c = 1'b1; end
         2'd2:    begin adj_src_c = areg[1][0]; adj_flip_c = 1'b1; end
         default: begin adj_src_c = areg[0][0]; adj_flip_c = 1'b0; end
      endcase
      adj_ext_c = (WIDTH + 1)'(adj_src_c);
      adj_mag_c = adj_ext_c[WIDTH] ? $unsigned(-adj_ext_c) : $unsigned(adj_ext_c);
      res_neg_c = adj_src_c[WIDTH-1] ^ adj_flip_c ^ det_neg_q;
      prod_c    = PW'(adj_mag_c) * PW'(recip_q);
      mag_c     = prod_c >> FRAC;
      if (SAT_EN) res_c = WIDTH'(sat_signed(SAT_MAG_W'(mag_c), res_neg_c, WIDTH));
      else        res_c = WIDTH'(res_neg_c ? (PW'(0) - mag_c) : mag_c);
   end

   // Operand latch, det sign, reciprocal, results and handshake outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
               areg[i][j] <= '0;
               Res[i][j]  <= '0;
            end
         end
         det_neg_q <= 1'b0;
         recip_q   <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         singular  <= 1'b0;
      end else if (clk_en) begin
         done <= (state == ST_DONE);
         busy <= (state_nxt != ST_IDLE) || (state == ST_DONE);
         if (state == ST_IDLE && start) areg <= A;
         if (state == ST_LATCH) begin
            det_neg_q <= det_c[DW-1];
            singular  <= det_zero_c;
            if (det_zero_c) begin
               for (int i = 0; i < 2; i++)
                  for (int j = 0; j < 2; j++)
                     Res[i][j] <= '0;
            end
         end
         if (state == ST_DIV && div_take_c) recip_q <= div_quot;
         if (is_mul_c) Res[mul_idx_c[1]][mul_idx_c[0]] <= res_c;
      end
   end

endmodule
